// File: rtl/rf_seq.sv
// Register-file control sequencer: latches one instruction on go and walks it
// through READ/EXEC/WRITE, driving the RF ports, ALU select and done handshake.
module rf_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic [2:0] op,
   input  logic [1:0] dst,
   input  logic [1:0] srca,
   input  logic [1:0] srcb,
   input  logic [2:0] imm,
   output logic       busy,
   output logic       done,
   output logic       rea,
   output logic       reb,
   output logic [1:0] raa,
   output logic [1:0] rab,
   output logic       we,
   output logic [1:0] wa,
   output logic       sel_imm,
   output logic [2:0] imm_q,
   output logic [1:0] alu_op,
   output logic       out_en
);

   typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LDI = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_MOV = 3'b110;
   localparam logic [2:0] OP_OUT = 3'b111;

   state_t     state, state_n;
   logic [2:0] op_r, op_n;
   logic [1:0] dst_r, dst_n;
   logic [1:0] srca_r, srca_n;
   logic [1:0] srcb_r, srcb_n;
   logic [2:0] imm_n;

   logic       busy_n, done_n, rea_n, reb_n, we_n, sel_imm_n, out_en_n;
   logic [1:0] raa_n, rab_n, wa_n, alu_op_n;
   logic       reading, b_used;

   // Next state and instruction register; the instruction only loads in IDLE
   always_comb begin
      state_n = state;
      op_n    = op_r;
      dst_n   = dst_r;
      srca_n  = srca_r;
      srcb_n  = srcb_r;
      imm_n   = imm_q;
      case (state)
         IDLE: begin
            if (go) begin
               op_n   = op;
               dst_n  = dst;
               srca_n = srca;
               srcb_n = srcb;
               imm_n  = imm;
               case (op)
                  OP_NOP:  state_n = DONE;
                  OP_LDI:  state_n = WRITE;
                  default: state_n = READ;
               endcase
            end
         end
         READ:    state_n = EXEC;
         EXEC:    state_n = (op_r == OP_OUT) ? DONE : WRITE;
         WRITE:   state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state so the registered copies
   // line up with the state they belong to (Moore, no output glitches)
   always_comb begin
      reading   = (state_n == READ) || (state_n == EXEC) ||
                  ((state_n == WRITE) && (op_n != OP_LDI));
      b_used    = (op_n != OP_MOV) && (op_n != OP_OUT);
      busy_n    = (state_n != IDLE);
      done_n    = (state_n == DONE);
      rea_n     = reading;
      raa_n     = reading ? srca_n : 2'b00;
      reb_n     = reading && b_used;
      rab_n     = (reading && b_used) ? srcb_n : 2'b00;
      we_n      = (state_n == WRITE);
      wa_n      = (state_n == WRITE) ? dst_n : 2'b00;
      sel_imm_n = (state_n == WRITE) && (op_n == OP_LDI);
      out_en_n  = (state_n == EXEC) && (op_n == OP_OUT);
      alu_op_n  = 2'b00;
      if (state_n != IDLE) begin
         case (op_n)
            OP_SUB:  alu_op_n = 2'b01;
            OP_AND:  alu_op_n = 2'b10;
            OP_OR:   alu_op_n = 2'b11;
            default: alu_op_n = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         op_r    <= 3'b000;
         dst_r   <= 2'b00;
         srca_r  <= 2'b00;
         srcb_r  <= 2'b00;
         imm_q   <= 3'b000;
         busy    <= 1'b0;
         done    <= 1'b0;
         rea     <= 1'b0;
         reb     <= 1'b0;
         raa     <= 2'b00;
         rab     <= 2'b00;
         we      <= 1'b0;
         wa      <= 2'b00;
         sel_imm <= 1'b0;
         alu_op  <= 2'b00;
         out_en  <= 1'b0;
      end else begin
         state   <= state_n;
         op_r    <= op_n;
         dst_r   <= dst_n;
         srca_r  <= srca_n;
         srcb_r  <= srcb_n;
         imm_q   <= imm_n;
         busy    <= busy_n;
         done    <= done_n;
         rea     <= rea_n;
         reb     <= reb_n;
         raa     <= raa_n;
         rab     <= rab_n;
         we      <= we_n;
         wa      <= wa_n;
         sel_imm <= sel_imm_n;
         alu_op  <= alu_op_n;
         out_en  <= out_en_n;
      end
   end

endmodule

// File: doc/rf_seq.md
# rf_seq

Control sequencer that drives the datapath's 4-entry × 3-bit register file. It sits on the initiator side of the RF port bundle (rea/reb/raa/rab/we/wa plus the din-source select) and turns one latched instruction into a fixed multi-cycle read/execute/write sequence. It also drives the ALU operation select and reports completion with a go/busy/done handshake to the top-level controller.

## Interface
Parameters:
- none; widths are fixed to the RF: 2-bit addresses, 3-bit data, 3-bit opcode.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- go  input  1  start request; sampled only in IDLE
- op  input  3  opcode, latched with go
- dst  input  2  destination register, latched with go
- srca  input  2  source A register, latched with go
- srcb  input  2  source B register, latched with go
- imm  input  3  immediate value, latched with go
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse in the DONE state
- rea, reb  output  1 each  RF read enables
- raa, rab  output  2 each  RF read addresses
- we  output  1  RF write enable
- wa  output  2  RF write address
- sel_imm  output  1  din mux select: 1 = imm_q, 0 = ALU result
- imm_q  output  3  latched immediate, fed to the din mux
- alu_op  output  2  ALU function: 00 ADD, 01 SUB, 10 AND, 11 OR
- out_en  output  1  strobe that captures RF port A into the display/output register

## Operation
- Opcodes:
  - 000 NOP
  - 001 LDI: dst ← imm
  - 010 ADD: dst ← A+B
  - 011 SUB: dst ← A−B
  - 100 AND
  - 101 OR
  - 110 MOV: dst ← A, issued as ADD with reb = 0, so port B reads 000
  - 111 OUT: strobe A to the output register
- States: IDLE, READ, EXEC, WRITE, DONE.
- IDLE with go = 1 latches op/dst/srca/srcb/imm into the instruction register, then branches:
  - NOP → DONE
  - LDI → WRITE
  - all other opcodes → READ
- READ → EXEC unconditionally.
- EXEC → WRITE for ALU ops and MOV; EXEC → DONE for OUT.
- WRITE → DONE; DONE → IDLE.
- Output decode, from state plus latched instruction:
  - READ and EXEC: rea = 1 and raa = srca; reb = 1 and rab = srcb, except MOV/OUT where reb = 0 and rab = 00.
  - WRITE: we = 1 and wa = dst. Reads stay asserted so the combinational din stays valid. sel_imm = 1 only for LDI.
  - EXEC (OUT only): out_en = 1.
  - alu_op is held from the latched opcode for the whole instruction. MOV/OUT/LDI/NOP use 00.
- Outputs not listed for a state are 0. That includes raa/rab/wa, which are 00 outside their active states.
- go seen while busy is ignored; no queueing. Inputs are don't-care outside the go cycle.
- Arithmetic is the ALU's job and wraps mod 8. This block does not inspect data.

## Timing
- All outputs are registered (Moore). They change only on a clk edge or on rst.
- Reset values:
  - state IDLE and instruction register 0
  - busy, done, rea, reb, we, sel_imm, out_en all 0
  - raa, rab, wa, alu_op 00; imm_q 000
- go sampled high at edge N gives these schedules (cycle = interval after the named edge):
  - ALU op/MOV: READ N+1, EXEC N+2, WRITE N+3 (RF writes at edge N+4), DONE N+4, IDLE N+5.
  - LDI: WRITE N+1, DONE N+2.
  - NOP: DONE N+1.
  - OUT: READ N+1, EXEC/out_en N+2, DONE N+3.
- we is high for exactly one cycle per write instruction, and never for NOP or OUT.
- Back-to-back instructions: go may be held high. A new instruction is accepted at the edge that leaves DONE→IDLE plus one, i.e. the first edge sampled in IDLE. Minimum spacing is the latency + 1.
- rst mid-instruction clears everything immediately, asynchronously. A write in progress is dropped (we falls before the edge). No done pulse is issued.

## Test plan
- Reset: assert rst mid-READ → all outputs 0 at once; state IDLE; the next go is accepted normally.
- LDI r2 ← 5: go at N → N+1 shows we = 1, wa = 10, sel_imm = 1, imm_q = 101; done at N+2; RF r2 = 5.
- ADD r3 ← r1 + r2 with r1 = 3, r2 = 6:
  - READ/EXEC/WRITE drive raa = 01, rab = 10, alu_op = 00.
  - we at N+3; RF r3 = 001 (wraps); done at N+4.
- MOV r0 ← r3 and OUT r0: MOV shows reb = 0 throughout and r0 = r3. OUT shows out_en for exactly one cycle at N+2, we never high, done at N+3.
- go held high continuously across four opcodes (NOP, LDI, SUB, OR) → each is accepted only from IDLE, with busy gaps matching the latencies above and exactly one done per instruction.
- go pulses during busy with changing op/dst → ignored; the latched instruction is unchanged and no extra done occurs.
